ex_muldiv: RTL and testbench

- EX-stage multiply/divide unit. It consumes the operation and operands produced by the ID/EX pipeline register: ex_aluop, ex_rs_data and ex_rt_data.
- It produces the 64-bit {HI,LO} result consumed by the EX→MEM path, and drives exe_stall (stall[2]) back to the pipeline control.
- Multiply completes in one cycle. Divide is an iterative radix-2 restoring divider that holds the pipeline while it runs.

---
 rtl/ex_muldiv.sv | 180 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: single-cycle 32x32 multiply and a
// fixed-latency radix-2 restoring divider that stalls the pipeline.
module ex_muldiv #(
  parameter logic [7:0] ALUOP_MULT  = 8'h18,
  parameter logic [7:0] ALUOP_MULTU = 8'h19,
  parameter logic [7:0] ALUOP_DIV   = 8'h1A,
  parameter logic [7:0] ALUOP_DIVU  = 8'h1B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic        mem_stall,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  output logic [31:0] muldiv_hi,
  output logic [31:0] muldiv_lo,
  output logic        muldiv_valid,
  output logic        exe_stall
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIV_ON  = 2'd1;
  localparam logic [1:0] S_DIV_END = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qsgn_q, qsgn_d;
  logic        rsgn_q, rsgn_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;

  logic        is_mult, is_multu, is_div, is_divu, is_dvop;
  logic [31:0] rs_abs, rt_abs;
  logic [63:0] prod;
  logic [64:0] sh;
  logic [32:0] trial;
  logic [63:0] step_w;
  logic [31:0] q_fin, r_fin;

  always_comb begin
    is_mult  = 1'b0;
    is_multu = 1'b0;
    is_div   = 1'b0;
    is_divu  = 1'b0;
    unique case (1'b1)
      (ex_aluop == ALUOP_MULT):  is_mult  = 1'b1;
      (ex_aluop == ALUOP_MULTU): is_multu = 1'b1;
      (ex_aluop == ALUOP_DIV):   is_div   = 1'b1;
      (ex_aluop == ALUOP_DIVU):  is_divu  = 1'b1;
      default: ;
    endcase
  end

  assign is_dvop = is_div | is_divu;

  // 0x80000000 maps onto itself, read back as unsigned 2^31
  assign rs_abs = (is_div && ex_rs_data[31]) ? -ex_rs_data : ex_rs_data;
  assign rt_abs = (is_div && ex_rt_data[31]) ? -ex_rt_data : ex_rt_data;

  always_comb begin
    if (is_mult)
      prod = $signed({{32{ex_rs_data[31]}}, ex_rs_data}) *
             $signed({{32{ex_rt_data[31]}}, ex_rt_data});
    else
      prod = {32'd0, ex_rs_data} * {32'd0, ex_rt_data};
  end

  // One restoring step: shift, trial-subtract, keep on no borrow
  always_comb begin
    sh    = {work_q, 1'b0};
    trial = sh[64:32] - {1'b0, dvs_q};
    if (!trial[32])
      step_w = {trial[31:0], sh[31:1], 1'b1};
    else
      step_w = sh[63:0];
  end

  assign q_fin = step_w[31:0];
  assign r_fin = step_w[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    qsgn_d   = qsgn_q;
    rsgn_d   = rsgn_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_dvop) begin
          dvs_d  = rt_abs;
          work_d = {32'd0, rs_abs};
          qsgn_d = is_div & (ex_rs_data[31] ^ ex_rt_data[31]);
          rsgn_d = is_div & ex_rs_data[31];
          cnt_d  = 5'd0;
          if (ex_rt_data == 32'd0) begin
            state_d  = S_DIV_END;
            res_hi_d = ex_rs_data;
            res_lo_d = 32'hFFFF_FFFF;
          end else begin
            state_d = S_DIV_ON;
          end
        end
      end
      S_DIV_ON: begin
        work_d = step_w;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DIV_END;
          res_lo_d = qsgn_q ? -q_fin : q_fin;
          res_hi_d = rsgn_q ? -r_fin : r_fin;
        end
      end
      S_DIV_END: begin
        if (!mem_stall)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (exception) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      work_q   <= 64'd0;
      dvs_q    <= 32'd0;
      qsgn_q   <= 1'b0;
      rsgn_q   <= 1'b0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      qsgn_q   <= qsgn_d;
      rsgn_q   <= rsgn_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  always_comb begin
    muldiv_hi    = 32'd0;
    muldiv_lo    = 32'd0;
    muldiv_valid = 1'b0;
    exe_stall    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_mult || is_multu) begin
            muldiv_hi    = prod[63:32];
            muldiv_lo    = prod[31:0];
            muldiv_valid = 1'b1;
          end else if (is_dvop) begin
            exe_stall = 1'b1;
          end
        end
        S_DIV_ON: exe_stall = 1'b1;
        S_DIV_END: begin
          muldiv_hi    = res_hi_q;
          muldiv_lo    = res_lo_q;
          muldiv_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: random and directed multiply/divide
// against an arithmetic reference model.
module tb_ex_muldiv;

  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
  localparam logic [7:0] OP_NOP   = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception;
  logic        mem_stall;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] muldiv_hi;
  logic [31:0] muldiv_lo;
  logic        muldiv_valid;
  logic        exe_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk          (clk),
    .rst          (rst),
    .exception    (exception),
    .mem_stall    (mem_stall),
    .ex_aluop     (ex_aluop),
    .ex_rs_data   (ex_rs_data),
    .ex_rt_data   (ex_rt_data),
    .muldiv_hi    (muldiv_hi),
    .muldiv_lo    (muldiv_lo),
    .muldiv_valid (muldiv_valid),
    .exe_stall    (exe_stall)
  );

  function automatic logic [63:0] model_mul(input logic [7:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint p;
    if (op == OP_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic void model_div(input logic [7:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] hi,
                                    output logic [31:0] lo);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (op == OP_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = 32'(q);
      hi = 32'(r);
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic do_mul(input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [63:0] exp_p;
    exp_p = model_mul(op, a, b);
    @(posedge clk); #1;
    ex_aluop = op; ex_rs_data = a; ex_rt_data = b;
    @(negedge clk);
    n_checks++;
    if ({muldiv_hi, muldiv_lo} !== exp_p) begin
      n_fail++;
      $display("FAIL %s: got hi/lo %h_%h, want %h", tag,
               muldiv_hi, muldiv_lo, exp_p);
    end
    n_checks++;
    if (muldiv_valid !== 1'b1 || exe_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s flags: got valid=%b stall=%b, want 1/0", tag,
               muldiv_valid, exe_stall);
    end
    ex_aluop = OP_NOP;
  endtask

  task automatic run_div(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag,
                         input bit scramble);
    logic [31:0] eh, el;
    int stalls, exp_stalls;
    bit done;
    model_div(op, a, b, eh, el);
    exp_stalls = (b == 32'd0) ? 1 : 33;
    @(posedge clk); #1;
    ex_aluop = op; ex_rs_data = a; ex_rt_data = b;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (exe_stall) begin
        stalls++;
        if (scramble && stalls > 1) begin
          ex_rs_data = $urandom;
          ex_rt_data = $urandom;
        end
      end else begin
        done = 1'b1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: stall still high after 100 cycles", tag);
    end
    n_checks++;
    if (stalls != exp_stalls) begin
      n_fail++;
      $display("FAIL %s latency: got %0d stall cycles, want %0d", tag,
               stalls, exp_stalls);
    end
    n_checks++;
    if (muldiv_valid !== 1'b1 || muldiv_hi !== eh || muldiv_lo !== el) begin
      n_fail++;
      $display("FAIL %s result: got v=%b hi=%h lo=%h, want v=1 hi=%h lo=%h",
               tag, muldiv_valid, muldiv_hi, muldiv_lo, eh, el);
    end
    ex_aluop = OP_NOP;
    @(negedge clk);
    n_checks++;
    if (muldiv_valid !== 1'b0 || exe_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: got valid=%b stall=%b, want 0/0", tag,
               muldiv_valid, exe_stall);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; exception = 1'b0; mem_stall = 1'b0;
    ex_aluop = OP_DIV; ex_rs_data = 32'd5; ex_rt_data = 32'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (exe_stall !== 1'b0 || muldiv_valid !== 1'b0 ||
          muldiv_hi !== 32'd0 || muldiv_lo !== 32'd0) begin
        n_fail++;
        $display("FAIL reset%0d: got stall=%b v=%b hi=%h lo=%h, want all 0",
                 i, exe_stall, muldiv_valid, muldiv_hi, muldiv_lo);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; ex_aluop = OP_NOP;
    @(negedge clk);
    n_checks++;
    if (exe_stall !== 1'b0 || muldiv_valid !== 1'b0 ||
        muldiv_hi !== 32'd0 || muldiv_lo !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset: got stall=%b v=%b hi=%h lo=%h, want all 0",
               exe_stall, muldiv_valid, muldiv_hi, muldiv_lo);
    end
  endtask

  task automatic test_mult;
    do_mul(OP_MULT,  32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    do_mul(OP_MULTU, 32'hFFFF_FFFE, 32'd3, "multu_neg2x3");
    do_mul(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minsq");
    for (int i = 0; i < 10; i++)
      do_mul((i % 2) ? OP_MULTU : OP_MULT, $urandom, $urandom, "mul_rand");
  endtask

  task automatic test_div;
    run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
    run_div(OP_DIVU, 32'hFFFF_FFF9, 32'd2, "divu_big_2", 1'b0);
    run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    run_div(OP_DIV,  32'd7, 32'hFFFF_FFFE, "div_7_m2", 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 255);
        2: b = -$urandom_range(1, 255);
        default: b = $urandom;
      endcase
      run_div((i % 2) ? OP_DIVU : OP_DIV, a, b, "div_rand", 1'b1);
    end
  endtask

  task automatic test_mem_stall;
    @(posedge clk); #1;
    ex_aluop = OP_DIV; ex_rs_data = 32'h1234; ex_rt_data = 32'd0;
    @(negedge clk);
    n_checks++;
    if (exe_stall !== 1'b1 || muldiv_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_detect: got stall=%b v=%b, want 1/0",
               exe_stall, muldiv_valid);
    end
    @(negedge clk);
    n_checks++;
    if (exe_stall !== 1'b0 || muldiv_valid !== 1'b1 ||
        muldiv_hi !== 32'h1234 || muldiv_lo !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL dz_end: got s=%b v=%b hi=%h lo=%h, want 0 1 1234 ffffffff",
               exe_stall, muldiv_valid, muldiv_hi, muldiv_lo);
    end
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (exe_stall !== 1'b0 || muldiv_valid !== 1'b1 ||
          muldiv_hi !== 32'h1234 || muldiv_lo !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL hold%0d: got s=%b v=%b hi=%h lo=%h, want 0 1 1234 ffffffff",
                 i, exe_stall, muldiv_valid, muldiv_hi, muldiv_lo);
      end
    end
    mem_stall = 1'b0;
    ex_aluop = OP_NOP;
    @(negedge clk);
    n_checks++;
    if (exe_stall !== 1'b0 || muldiv_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got stall=%b v=%b, want 0/0",
               exe_stall, muldiv_valid);
    end
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    ex_aluop = OP_DIV; ex_rs_data = $urandom; ex_rt_data = 32'd13;
    @(negedge clk);
    repeat (11) @(negedge clk);
    n_checks++;
    if (exe_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: got stall=%b, want 1", exe_stall);
    end
    exception = 1'b1;
    ex_aluop = OP_NOP;
    @(negedge clk);
    exception = 1'b0;
    n_checks++;
    if (exe_stall !== 1'b0 || muldiv_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: got stall=%b v=%b, want 0/0",
               exe_stall, muldiv_valid);
    end
    @(negedge clk);
    n_checks++;
    if (muldiv_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_noresult: got v=%b, want 0", muldiv_valid);
    end
    run_div(OP_DIVU, 32'd100, 32'd7, "divu_after_flush", 1'b0);
  endtask

  task automatic test_back_to_back;
    run_div(OP_DIV, 32'hFFFF_FF00, 32'd16, "b2b_div", 1'b0);
    do_mul(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_mult");
    run_div(OP_DIVU, 32'd0, 32'd9, "b2b_divu0", 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mem_stall();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
